// File: rtl/shift_seq_ctrl.sv
// Round-robin controller that loads one of two W-bit patterns and streams it
// MSB-first to a serial shift register, one strobe every DIV clocks.
module shift_seq_ctrl #(
    parameter int W   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    input  logic         stall,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic         shift_en,
    output logic         shift_din,
    output logic [1:0]   done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     done_q, done_d;
    logic           en_q, en_d;
    logic           din_q, din_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bitcnt_q, bitcnt_d;
    logic [W-1:0]   buf_q, buf_d;
    // 1 means requester 1 was granted last, so requester 0 wins a tie
    logic           last_q, last_d;
    logic           win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            en_q     <= 1'b0;
            din_q    <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            buf_q    <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            en_q     <= en_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            buf_q    <= buf_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        en_d     = 1'b0;
        din_d    = din_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        buf_d    = buf_q;
        last_d   = last_q;
        win      = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d    = win ? 2'b10 : 2'b01;
                    buf_d    = win ? data1 : data0;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST && !stall) begin
                    en_d     = 1'b1;
                    din_d    = buf_q[W-1];
                    buf_d    = {buf_q[W-2:0], 1'b0};
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + 1'b1;
                    // Last strobe: done is registered so it lines up with this pulse
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = S_DONE;
                        done_d  = gnt_q;
                    end
                end else if (!stall) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign shift_en  = en_q;
    assign shift_din = din_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: DIV=4 and DIV=1 instances share stimulus and are
// checked every cycle against a transfer-level model, plus directed literal checks.
module tb_shift_seq_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req   = 2'b00;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         stall = 1'b0;

    logic [1:0] gnt_w  [2];
    logic       busy_w [2];
    logic       en_w   [2];
    logic       din_w  [2];
    logic [1:0] done_w [2];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.W(W), .DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .stall(stall), .gnt(gnt_w[0]), .busy(busy_w[0]), .shift_en(en_w[0]),
        .shift_din(din_w[0]), .done(done_w[0])
    );

    shift_seq_ctrl #(.W(W), .DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .stall(stall), .gnt(gnt_w[1]), .busy(busy_w[1]), .shift_en(en_w[1]),
        .shift_din(din_w[1]), .done(done_w[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[inst%0d] t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    bit           m_active [2];
    bit           m_indone [2];
    bit           m_win    [2];
    bit           m_prio   [2];   // requester that wins a tie
    logic [W-1:0] m_buf    [2];
    int           m_left   [2];
    int           m_wait   [2];
    logic [1:0]   e_gnt    [2];
    logic [1:0]   e_done   [2];
    logic         e_busy   [2];
    logic         e_en     [2];
    logic         e_din    [2];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_active[k] = 0; m_indone[k] = 0; m_win[k] = 0; m_prio[k] = 0;
                m_buf[k] = '0; m_left[k] = 0; m_wait[k] = 0;
                e_gnt[k] = 2'b00; e_done[k] = 2'b00; e_busy[k] = 0; e_en[k] = 0; e_din[k] = 0;
            end else begin
                e_done[k] = 2'b00;
                e_en[k]   = 1'b0;
                if (m_indone[k]) begin
                    m_indone[k] = 0;
                    m_prio[k]   = ~m_win[k];
                    e_gnt[k]    = 2'b00;
                end else if (m_active[k]) begin
                    if (!stall) begin
                        m_wait[k]--;
                        if (m_wait[k] == 0) begin
                            e_en[k]   = 1'b1;
                            e_din[k]  = m_buf[k][W-1];
                            m_buf[k]  = m_buf[k] << 1;
                            m_left[k]--;
                            m_wait[k] = div_of(k);
                            if (m_left[k] == 0) begin
                                m_active[k] = 0;
                                m_indone[k] = 1;
                                e_done[k]   = m_win[k] ? 2'b10 : 2'b01;
                            end
                        end
                    end
                end else if (req != 2'b00) begin
                    m_win[k]    = (req == 2'b11) ? m_prio[k] : req[1];
                    m_buf[k]    = m_win[k] ? data1 : data0;
                    m_left[k]   = W;
                    m_wait[k]   = div_of(k);
                    m_active[k] = 1;
                    e_gnt[k]    = m_win[k] ? 2'b10 : 2'b01;
                end
                e_busy[k] = m_active[k] || m_indone[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("gnt", k, 8'(gnt_w[k]), 8'(e_gnt[k]));
            check("busy", k, 8'(busy_w[k]), 8'(e_busy[k]));
            check("shift_en", k, 8'(en_w[k]), 8'(e_en[k]));
            check("done", k, 8'(done_w[k]), 8'(e_done[k]));
            if (e_en[k]) check("shift_din", k, 8'(din_w[k]), 8'(e_din[k]));
        end
    end

    // ---------------- observed-transfer monitor ----------------
    logic [7:0] bits    [2];
    int         nb      [2];
    int         first_c [2];
    int         last_c  [2];
    int         dcount  [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            bits[k] = 0; nb[k] = 0; first_c[k] = 0; last_c[k] = 0; dcount[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!busy_w[k]) begin
                    nb[k] = 0; bits[k] = 0;
                end else if (en_w[k]) begin
                    if (nb[k] == 0) first_c[k] = cyc;
                    last_c[k] = cyc;
                    bits[k] = {bits[k][6:0], din_w[k]};
                    nb[k]++;
                end
                if (done_w[k] != 2'b00) dcount[k]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] r);
        reset = 1'b1; req = 2'b00; stall = 1'b0;
        step(); step();
        req = r; reset = 1'b0;
    endtask

    task automatic wait_nbits(input int k, input int n);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (nb[k] >= n) ok = 1;
        end
        check("wait_bits_timeout", k, 8'(ok), 8'd1);
    endtask

    task automatic wait_done(input int k);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (done_w[k] != 2'b00) ok = 1;
        end
        check("wait_done_timeout", k, 8'(ok), 8'd1);
    endtask

    logic [1:0] exp_g [3];
    logic [7:0] exp_b [3];
    int base;

    initial begin
        // Basic transfer of A5 from requester 0
        data0 = 8'hA5; data1 = 8'h5A;
        do_reset(2'b01);
        @(negedge clk); #1;
        check("gnt_before_grant", 0, 8'(gnt_w[0]), 8'h00);
        @(negedge clk); #1;
        check("gnt_after_grant", 0, 8'(gnt_w[0]), 8'h01);
        check("busy_after_grant", 0, 8'(busy_w[0]), 8'h01);
        wait_done(0);
        check("t1_bits", 0, bits[0], 8'hA5);
        check("t1_nbits", 0, 8'(nb[0]), 8'd8);
        check("t1_span", 0, 8'(last_c[0] - first_c[0]), 8'd28);
        check("t1_done", 0, 8'(done_w[0]), 8'h01);
        step(); req = 2'b00;
        @(negedge clk); #1;
        check("t1_gnt_idle", 0, 8'(gnt_w[0]), 8'h00);
        check("t1_busy_idle", 0, 8'(busy_w[0]), 8'h00);

        // Both requesters held: strict alternation
        data0 = 8'hFF; data1 = 8'h00;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_b[0] = 8'hFF; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
        do_reset(2'b11);
        for (int t = 0; t < 3; t++) begin
            wait_done(0);
            check("t2_done_who", 0, 8'(done_w[0]), 8'(exp_g[t]));
            check("t2_bits", 0, bits[0], exp_b[t]);
        end
        step(); req = 2'b00;

        // Stall for 10 cycles after the 3rd strobe
        data0 = 8'hA5;
        do_reset(2'b01);
        base = dcount[0];
        wait_nbits(0, 3);
        step(); stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        stall = 1'b0;
        wait_done(0);
        check("t3_bits", 0, bits[0], 8'hA5);
        check("t3_span", 0, 8'(last_c[0] - first_c[0]), 8'd38);
        step(); req = 2'b00;
        for (int i = 0; i < 20; i++) step();
        check("t3_done_count", 0, 8'(dcount[0] - base), 8'd1);

        // Drop req and change data mid-transfer
        data0 = 8'hA5;
        do_reset(2'b01);
        wait_nbits(0, 2);
        step(); req = 2'b00; data0 = 8'h00;
        wait_done(0);
        check("t4_bits", 0, bits[0], 8'hA5);
        check("t4_done", 0, 8'(done_w[0]), 8'h01);
        for (int i = 0; i < 20; i++) step();
        check("t4_no_regrant", 0, 8'(gnt_w[0]), 8'h00);

        // Reset mid-transfer
        data0 = 8'hA5;
        do_reset(2'b01);
        base = dcount[0];
        wait_nbits(0, 3);
        reset = 1'b1;
        #1;
        check("t5_gnt_rst", 0, 8'(gnt_w[0]), 8'h00);
        check("t5_busy_rst", 0, 8'(busy_w[0]), 8'h00);
        check("t5_en_rst", 0, 8'(en_w[0]), 8'h00);
        check("t5_no_done", 0, 8'(dcount[0] - base), 8'd0);
        step(); step();
        req = 2'b11; reset = 1'b0;
        step();
        @(negedge clk); #1;
        check("t5_ptr_reset", 0, 8'(gnt_w[0]), 8'h01);

        // DIV=1 instance streams 3C back to back
        data1 = 8'h3C;
        do_reset(2'b10);
        wait_done(1);
        check("t6_bits", 1, bits[1], 8'h3C);
        check("t6_nbits", 1, 8'(nb[1]), 8'd8);
        check("t6_span", 1, 8'(last_c[1] - first_c[1]), 8'd7);
        check("t6_done", 1, 8'(done_w[1]), 8'h02);

        // Randomised traffic, checked by the model every cycle
        do_reset(2'b00);
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0; req = 2'b00;
        for (int i = 0; i < 50; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Controller that sequences a serial-in shift register (W-bit) on behalf of two requesters.
- Arbitrates round-robin between requesters, captures the winner's W-bit pattern, and streams it MSB-first.
- Each bit is emitted as a one-cycle shift_en strobe plus shift_din, paced by an internal divide-by-DIV strobe generator.
- Sits between the key/switch request logic and the shift register in the lab top; drives the shift register's en and serial data input.

Parameters:
W, 8, pattern width = number of shifts per transfer (W >= 2)
DIV, 4, clk cycles between consecutive shift strobes (DIV >= 1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
req  in  2  level request per requester; bit i = requester i
data0  in  W  pattern of requester 0, sampled only at grant
data1  in  W  pattern of requester 1, sampled only at grant
stall  in  1  freeze pacing: holds strobe counter, suppresses shift_en
gnt  out  2  one-hot grant, registered
busy  out  1  high whenever state != IDLE
shift_en  out  1  registered one-cycle pulse to shift register enable
shift_din  out  1  registered serial bit, valid while shift_en = 1
done  out  2  one-cycle completion pulse to the granted requester

Behaviour:
- Reset (async, immediate): state = IDLE; gnt, busy, shift_en, shift_din, done = 0; strobe counter, bit counter and buffer = 0; RR pointer = "requester 0 has priority".
- Reset mid-transfer aborts the transfer with no done pulse; outputs drop immediately.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, no request: hold.
- IDLE, any req bit high at posedge g:
  - Choose the winner: single requester wins; if both, the one not granted last wins; after reset, 0 wins.
  - Set gnt one-hot.
  - Load buffer from the winner's data.
  - Clear strobe counter and bit counter; go to SHIFT.
  - gnt is visible from edge g.
- SHIFT, strobe condition = (cnt == DIV-1) && !stall:
  - Condition true at an edge: shift_en <= 1; shift_din <= buf[W-1]; buf <<= 1; bitcnt++; cnt <= 0.
  - Otherwise: shift_en <= 0; cnt++ unless stall (stall holds cnt); shift_din holds its last value.
- SHIFT timing: first shift_en is high in the cycle after edge g+DIV. Strobes are spaced DIV cycles apart (plus any stall cycles).
- DIV = 1: cnt stays 0; shift_en is high on every non-stalled cycle.
- SHIFT exit: the edge that issues the W-th strobe (bitcnt == W-1) also moves to DONE.
- DONE (exactly one cycle):
  - done = gnt, decoded from registers, glitch-free; it coincides with the last shift_en pulse.
  - RR pointer records the winner.
  - Next edge: gnt <= 0, go to IDLE.
- Re-grant: earliest new grant is one edge after IDLE entry, so gnt is low for at least one cycle between transfers.
- req is sampled only in IDLE:
  - Dropping req mid-transfer does not abort; all W bits are sent and done pulses anyway.
  - A held req is re-arbitrated in IDLE.
  - Both reqs held gives strict alternation.
- data0/data1 changes after grant have no effect on the current transfer.
- stall in IDLE or DONE: no effect. stall during SHIFT only stretches pacing; bit order is unaffected.
- Invariants: gnt is at most one-hot; done is never nonzero outside DONE; exactly W shift_en pulses per completed transfer.

Test Plan:
- W=8, DIV=4: release reset, req=01, data0=8'hA5.
  - gnt=01 next edge.
  - 8 shift_en pulses, 4 cycles apart; shift_din = 1,0,1,0,0,1,0,1.
  - done=01 with the 8th pulse; gnt and busy = 0 one cycle later.
- req=11 held from reset, data0=8'hFF, data1=8'h00:
  - grants alternate 01,10,01 with one idle cycle between.
  - shift_din all 1s for requester 0, all 0s for requester 1.
- stall=1 for 10 cycles after the 3rd shift_en:
  - no shift_en during stall; remaining pulses delayed by exactly 10 cycles.
  - bit sequence of 8'hA5 intact; done still pulses once.
- req0 deasserted after the 2nd bit, data0 changed to 8'h00 mid-transfer:
  - original 8'hA5 fully shifted; done=01; no new grant afterwards.
- reset pulsed after the 3rd bit:
  - gnt, busy, shift_en = 0 immediately, no done.
  - after release with req=11, gnt=01 (pointer reset).
- DIV=1 instance, data1=8'h3C, req=10:
  - shift_en high for 8 consecutive cycles; shift_din = 0,0,1,1,1,1,0,0; done=10 on the 8th.
